// File: rtl/cu_if.sv
// rtl/cu_if.sv - instruction fetch unit with local instruction memory
//
// Purpose: accepts a fetch request from the control unit, reads one 32-bit
// word from a loadable instruction memory and presents it to the decoder.
// States are IDLE, READ and DONE.
//
// Ports:
//   soc_clk        in   1   clock, all state on rising edge
//   reset          in   1   synchronous active-high reset
//   memfetch_start in   1   fetch request
//   fetch_pc       in  32   byte address to fetch, valid with memfetch_start
//   IF_stall       in   1   consumer not ready; holds a completed fetch
//   imem_we        in   1   instruction memory load strobe
//   imem_waddr     in   7   word index to load
//   imem_wdata     in  32   word to load
//   Fetch_ready    out  1   Cu_IR / fetch_err valid
//   Cu_IR          out 32   fetched instruction word
//   fetch_err      out  1   misaligned or out-of-range PC
//   fetch_busy     out  1   high while in READ
//   fetch_overrun  out  1   sticky: a request was dropped
//   fetch_count    out 16   completed fetches, wraps

module cu_if #(
    parameter int IMEM_WORDS = 128
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        memfetch_start,
    input  logic [31:0] fetch_pc,
    input  logic        IF_stall,
    input  logic        imem_we,
    input  logic [6:0]  imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic        Fetch_ready,
    output logic [31:0] Cu_IR,
    output logic        fetch_err,
    output logic        fetch_busy,
    output logic        fetch_overrun,
    output logic [15:0] fetch_count
);

    localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_err;
    logic        r_overrun;
    logic [15:0] r_count;
    logic [31:0] r_imem [IMEM_WORDS];

    logic          w_accept;
    logic          w_drop;
    logic          w_pc_err;
    logic          w_wr_ok;
    logic [AW-1:0] w_ridx;
    logic [AW-1:0] w_widx;

    // Full 32-bit range compare so high address bits are not silently aliased.
    assign w_pc_err = (r_pc[1:0] != 2'b00) || (r_pc >= 32'(4 * IMEM_WORDS));
    assign w_ridx   = r_pc[AW+1:2];
    assign w_widx   = AW'(imem_waddr);
    assign w_wr_ok  = ({25'd0, imem_waddr} < 32'(IMEM_WORDS));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (memfetch_start) begin
                    w_accept = 1'b1;
                    w_next   = S_READ;
                end
            end
            S_READ: begin
                w_next = S_DONE;
                w_drop = memfetch_start;
            end
            S_DONE: begin
                if (IF_stall) begin
                    w_drop = memfetch_start;
                end else if (memfetch_start) begin
                    // Back-to-back: new request accepted as the result is consumed.
                    w_accept = 1'b1;
                    w_next   = S_READ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Memory has no reset so loaded code survives a core reset. Non-blocking
    // write gives read-before-write on a same-edge load and READ.
    always_ff @(posedge soc_clk) begin
        if (imem_we && w_wr_ok) begin
            r_imem[w_widx] <= imem_wdata;
        end
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= 32'd0;
            r_ir      <= 32'd0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pc <= fetch_pc;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_READ) begin
                r_ir    <= w_pc_err ? 32'd0 : r_imem[w_ridx];
                r_err   <= w_pc_err;
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign Fetch_ready   = (r_state == S_DONE);
    assign fetch_busy    = (r_state == S_READ);
    assign Cu_IR         = r_ir;
    assign fetch_err     = r_err;
    assign fetch_overrun = r_overrun;
    assign fetch_count   = r_count;

endmodule
